// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory fetch path: FSM states,
// defaults and the byte-address split used by the responder, PC and IFU.
package imem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned WAIT_W = 4;
  localparam logic [WORD_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [29:0] word;
    logic        err;
  } addr_split_t;

  // Word index plus error flag: misaligned, or above the aw-bit word space.
  function automatic addr_split_t split_addr(input logic [31:0] addr, input int unsigned aw);
    addr_split_t s;
    s.word = addr[31:2];
    s.err  = (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
    return s;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-port DEPTH_WORDS x 32 RAM with registered read. The read register can
// be loaded with a substitute word instead of the array contents.
module imem_ram
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           we,
  input  logic                           re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [WORD_W-1:0]              wdata,
  input  logic                           override,
  input  logic [WORD_W-1:0]              override_data,
  output logic [WORD_W-1:0]              rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register holds its value between reads; contents survive reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= override ? override_data : mem[addr];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: host load port plus a wait-stated fetch port
// that returns one word per request with a one-cycle valid pulse.
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 256,
  parameter int unsigned       WAIT_STATES = 1,
  parameter logic [WORD_W-1:0] NOP_WORD    = NOP_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic [WORD_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic              fetch_err,
  output logic              fetch_busy,
  input  logic              load_en,
  input  logic [31:0]       load_addr,
  input  logic [WORD_W-1:0] load_data,
  output logic              load_ready,
  output logic [15:0]       load_count
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [AW-1:0]     idx_q, idx_nxt;
  logic              err_q, err_nxt;
  logic              load_accept;
  logic              ram_we, ram_re, ram_override;
  logic [AW-1:0]     ram_addr;
  addr_split_t       fetch_split, load_split;

  assign fetch_split = split_addr(fetch_addr, AW);
  assign load_split  = split_addr(load_addr, AW);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state plus RAM arbitration; loads win over fetches in IDLE.
  always_comb begin
    next_state   = state;
    wait_cnt_nxt = wait_cnt;
    idx_nxt      = idx_q;
    err_nxt      = err_q;
    load_accept  = 1'b0;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_addr     = idx_q;
    ram_override = err_q;
    case (state)
      IDLE: begin
        if (load_en) begin
          load_accept = 1'b1;
          ram_addr    = AW'(load_split.word);
          ram_we      = !load_split.err;
        end else if (fetch_req) begin
          idx_nxt      = AW'(fetch_split.word);
          err_nxt      = fetch_split.err;
          wait_cnt_nxt = WAIT_W'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            next_state   = RESP;
            ram_re       = 1'b1;
            ram_addr     = AW'(fetch_split.word);
            ram_override = fetch_split.err;
          end else begin
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt != '0) begin
          wait_cnt_nxt = wait_cnt - WAIT_W'(1);
        end
        if (wait_cnt <= WAIT_W'(1)) begin
          next_state = RESP;
          ram_re     = 1'b1;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      fetch_busy  <= 1'b0;
      load_ready  <= 1'b1;
      load_count  <= '0;
    end else begin
      wait_cnt    <= wait_cnt_nxt;
      idx_q       <= idx_nxt;
      err_q       <= err_nxt;
      fetch_valid <= (next_state == RESP);
      fetch_err   <= (next_state == RESP) && err_nxt;
      fetch_busy  <= (next_state != IDLE);
      load_ready  <= (next_state == IDLE);
      if (load_accept && (load_count != 16'hFFFF)) begin
        load_count <= load_count + 16'd1;
      end
    end
  end

  imem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk          (clk),
    .reset        (reset),
    .we           (ram_we && !reset),
    .re           (ram_re),
    .addr         (ram_addr),
    .wdata        (load_data),
    .override     (ram_override),
    .override_data(NOP_WORD),
    .rdata        (fetch_data)
  );

endmodule
